// File: rtl/io_buf_bank.sv
// io_buf_bank: registered bidirectional pad bank with a shared direction control.
// Direction changes go through a turnaround FSM with dead cycles. The receive path
// synchronises, glitch-filters and change-detects every pad bit in all states.
module io_buf_bank #(
    parameter int unsigned WIDTH       = 8,
    parameter string       WEAK_KEEPER = "NONE",
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TURNAROUND  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dir_req_i,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_chg_o,
    output logic             dir_ack_o,
    output logic             busy_o,
    inout  wire  [WIDTH-1:0] io_io
);

    typedef enum logic [1:0] {
        StRx,
        StTaTx,
        StTx,
        StTaRx
    } state_e;

    localparam logic [3:0] TaLoad = 4'(TURNAROUND - 1);

    state_e                           state_q, state_d;
    logic [3:0]                       ta_cnt_q, ta_cnt_d;
    logic                             oe_q;
    logic [WIDTH-1:0]                 out_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                 synced;
    logic [WIDTH-1:0]                 rx_data_q;
    logic                             rx_chg_q;

    // Keeper is attached per bit so it survives while the bank is released.
    if (WEAK_KEEPER == "PULLUP") begin : g_keep_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pullup u_pu (io_io[i]);
        end
    end else if (WEAK_KEEPER == "PULLDOWN") begin : g_keep_dn
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pulldown u_pd (io_io[i]);
        end
    end

    // Next-state logic: turnarounds always run to completion, DIR_REQ is ignored meanwhile.
    always_comb begin
        state_d  = state_q;
        ta_cnt_d = ta_cnt_q;
        unique case (state_q)
            StRx: begin
                if (dir_req_i) begin
                    state_d  = StTaTx;
                    ta_cnt_d = TaLoad;
                end
            end
            StTaTx: begin
                if (ta_cnt_q == 4'd0) begin
                    state_d = StTx;
                end else begin
                    ta_cnt_d = ta_cnt_q - 4'd1;
                end
            end
            StTx: begin
                if (!dir_req_i) begin
                    state_d  = StTaRx;
                    ta_cnt_d = TaLoad;
                end
            end
            StTaRx: begin
                if (ta_cnt_q == 4'd0) begin
                    state_d = StRx;
                end else begin
                    ta_cnt_d = ta_cnt_q - 4'd1;
                end
            end
            default: state_d = StRx;
        endcase
    end

    // State register and turnaround counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StRx;
            ta_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            ta_cnt_q <= ta_cnt_d;
        end
    end

    // Drive register: enable follows the next state so it rises with TX entry and
    // drops on the same edge that leaves TX; data is captured on every TX cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oe_q  <= 1'b0;
            out_q <= '0;
        end else begin
            oe_q <= (state_d == StTx);
            if (state_d == StTx) begin
                out_q <= tx_data_i;
            end
        end
    end

    assign io_io = oe_q ? out_q : {WIDTH{1'bz}};

    // Receive synchroniser, active in every state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_io};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    if (FILTER_LEN == 0) begin : g_bypass
        // Unfiltered: one register stage after the synchroniser.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rx_data_q <= '0;
                rx_chg_q  <= 1'b0;
            end else begin
                rx_data_q <= synced;
                rx_chg_q  <= |(synced ^ rx_data_q);
            end
        end
    end else begin : g_filter
        localparam int unsigned  CntW    = $clog2(FILTER_LEN + 1);
        localparam logic [CntW-1:0] CntMax  = CntW'(FILTER_LEN);
        localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

        logic [WIDTH-1:0]            prev_q;
        logic [WIDTH-1:0][CntW-1:0]  cnt_q, cnt_d;
        logic [WIDTH-1:0]            rx_d;

        // Per-bit stability counter: restarts on any sample-to-sample change and
        // commits the new value once it has held for FILTER_LEN counts.
        always_comb begin
            cnt_d = cnt_q;
            rx_d  = rx_data_q;
            for (int i = 0; i < WIDTH; i++) begin
                if ((synced[i] == rx_data_q[i]) || (synced[i] != prev_q[i])) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntLast) begin
                    rx_d[i]  = synced[i];
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != CntMax) begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end

        // Filter state, filtered output and change pulse.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                prev_q    <= '0;
                cnt_q     <= '0;
                rx_data_q <= '0;
                rx_chg_q  <= 1'b0;
            end else begin
                prev_q    <= synced;
                cnt_q     <= cnt_d;
                rx_data_q <= rx_d;
                rx_chg_q  <= |(rx_d ^ rx_data_q);
            end
        end
    end

    assign rx_data_o = rx_data_q;
    assign rx_chg_o  = rx_chg_q;
    assign dir_ack_o = (state_q == StTx);
    assign busy_o    = (state_q == StTaTx) || (state_q == StTaRx);

endmodule

// File: tb/tb_io_buf_bank.sv
// Directed bench for io_buf_bank: a default 8-bit bank plus a 1-bit unfiltered bank.
// Expected values are queued when stimulus is applied and popped at each sample point.
module tb_io_buf_bank;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         dir_req;
    logic [W-1:0] tx_data;
    logic [W-1:0] rx_data;
    logic         rx_chg;
    logic         dir_ack;
    logic         busy;
    wire  [W-1:0] io;
    logic         pad_en;
    logic [W-1:0] pad_val;

    logic         w1_rx;
    logic         w1_chg;
    logic         w1_ack;
    logic         w1_busy;
    logic         w1_pad;
    wire          w1_io;

    int n_vec  = 0;
    int n_miss = 0;
    int chg_cnt = 0;
    int w1_cnt  = 0;
    int chg_base;
    int w1_base;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    assign io    = pad_en ? pad_val : {W{1'bz}};
    assign w1_io = w1_pad;

    io_buf_bank #(
        .WIDTH      (W),
        .WEAK_KEEPER("NONE"),
        .SYNC_STAGES(2),
        .FILTER_LEN (4),
        .TURNAROUND (2)
    ) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .dir_req_i(dir_req),
        .tx_data_i(tx_data),
        .rx_data_o(rx_data),
        .rx_chg_o (rx_chg),
        .dir_ack_o(dir_ack),
        .busy_o   (busy),
        .io_io    (io)
    );

    io_buf_bank #(
        .WIDTH      (1),
        .WEAK_KEEPER("NONE"),
        .SYNC_STAGES(2),
        .FILTER_LEN (0),
        .TURNAROUND (2)
    ) u_w1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .dir_req_i(1'b0),
        .tx_data_i(1'b0),
        .rx_data_o(w1_rx),
        .rx_chg_o (w1_chg),
        .dir_ack_o(w1_ack),
        .busy_o   (w1_busy),
        .io_io    (w1_io)
    );

    always #5 clk = ~clk;

    // Change pulses are counted on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_chg) chg_cnt <= chg_cnt + 1;
        if (w1_chg) w1_cnt <= w1_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_miss++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        dir_req = 1'b0;
        tx_data = '0;
        pad_en  = 1'b1;
        pad_val = 8'hFF;
        w1_pad  = 1'b0;
        cyc(2);

        // Reset state with pads pulled high by the bench.
        push("rst_rx_data", 32'h00); pop_cmp(32'(rx_data));
        push("rst_status", 32'h0);   pop_cmp(32'({rx_chg, dir_ack, busy}));
        push("rst_io", 32'hFF);      pop_cmp(32'(io));
        push("rst_w1_rx", 32'h0);    pop_cmp(32'(w1_rx));

        rst      = 1'b0;
        chg_base = chg_cnt;
        push("settle_rx_6", 32'h00);
        cyc(6);
        pop_cmp(32'(rx_data));
        push("settle_rx_7", 32'hFF);
        push("settle_chg_7", 32'h1);
        cyc(1);
        pop_cmp(32'(rx_data));
        pop_cmp(32'(rx_chg));
        push("settle_pulses", 32'd1);
        cyc(3);
        pop_cmp(32'(chg_cnt - chg_base));

        // Glitch filter on bit 3.
        pad_val = 8'hF7;
        push("base_rx", 32'hF7);
        cyc(10);
        pop_cmp(32'(rx_data));
        chg_base = chg_cnt;
        pad_val  = 8'hFF;
        cyc(3);
        pad_val  = 8'hF7;
        push("glitch3_rx", 32'hF7);
        push("glitch3_pulses", 32'd0);
        cyc(10);
        pop_cmp(32'(rx_data));
        pop_cmp(32'(chg_cnt - chg_base));
        chg_base = chg_cnt;
        pad_val  = 8'hFF;
        push("pulse_rx_6", 32'hF7);
        cyc(6);
        pop_cmp(32'(rx_data));
        push("pulse_rx_7", 32'hFF);
        cyc(1);
        pop_cmp(32'(rx_data));
        push("pulse_pulses", 32'd1);
        cyc(3);
        pop_cmp(32'(chg_cnt - chg_base));

        // RX -> TX with two dead cycles.
        dir_req = 1'b1;
        tx_data = 8'hA5;
        push("tatx1_st", 32'b01);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        push("tatx2_st", 32'b01);
        push("tatx2_io", 32'hFF);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        pop_cmp(32'(io));
        pad_en = 1'b0;
        push("tx_st", 32'b10);
        push("tx_io", 32'hA5);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        pop_cmp(32'(io));
        tx_data = 8'h3C;
        push("tx_io_next", 32'h3C);
        cyc(1);
        pop_cmp(32'(io));
        push("tx_rx_own", 32'h3C);
        cyc(8);
        pop_cmp(32'(rx_data));

        // DIR_REQ dips for one cycle: full TA_RX, one RX cycle, full TA_TX.
        dir_req = 1'b0;
        push("tarx1_st", 32'b01);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        dir_req = 1'b1;
        pad_en  = 1'b1;
        pad_val = 8'h00;
        push("tarx2_st", 32'b01);
        push("tarx2_io", 32'h00);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        pop_cmp(32'(io));
        push("rx_gap_st", 32'b00);
        push("rx_gap_io", 32'h00);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        pop_cmp(32'(io));
        push("retatx1_st", 32'b01);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        push("retatx2_st", 32'b01);
        push("retatx2_io", 32'h00);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        pop_cmp(32'(io));
        pad_en = 1'b0;
        push("retx_st", 32'b10);
        push("retx_io", 32'h3C);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        pop_cmp(32'(io));

        // Reset in the middle of TX releases the pads at once.
        rst     = 1'b1;
        pad_en  = 1'b1;
        pad_val = 8'h00;
        #1;
        push("rst_mid_io", 32'h00);
        push("rst_mid_st", 32'h0);
        push("rst_mid_rx", 32'h00);
        pop_cmp(32'(io));
        pop_cmp(32'({rx_chg, dir_ack, busy}));
        pop_cmp(32'(rx_data));
        cyc(1);
        rst = 1'b0;
        push("rst_tatx1", 32'b01);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        push("rst_tatx2", 32'b01);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        pad_en = 1'b0;
        push("rst_tx_st", 32'b10);
        push("rst_tx_io", 32'h3C);
        cyc(1);
        pop_cmp(32'({dir_ack, busy}));
        pop_cmp(32'(io));

        // 1-bit bank without filter: SYNC_STAGES+1 lag, one pulse per edge.
        w1_base = w1_cnt;
        w1_pad  = 1'b1;
        push("w1_rise_2", 32'h0);
        cyc(2);
        pop_cmp(32'(w1_rx));
        push("w1_rise_3", 32'h1);
        push("w1_rise_chg", 32'h1);
        cyc(1);
        pop_cmp(32'(w1_rx));
        pop_cmp(32'(w1_chg));
        w1_pad = 1'b0;
        push("w1_fall_2", 32'h1);
        cyc(2);
        pop_cmp(32'(w1_rx));
        push("w1_fall_3", 32'h0);
        cyc(1);
        pop_cmp(32'(w1_rx));
        push("w1_pulses", 32'd2);
        cyc(2);
        pop_cmp(32'(w1_cnt - w1_base));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/io_buf_bank.md
Name: io_buf_bank

Overview:
- Parametrised, registered successor to the single-bit input, output and tristate buffer wrappers.
- Drives a WIDTH-bit bidirectional pad bus through one shared direction control.
- Direction changes pass through a turnaround state machine with guaranteed dead cycles. The receive path has a synchroniser, a per-bit glitch filter and a change-detect pulse.
- Sits between fabric logic and the per-bit I/O primitives, one instance per pad group.

Parameters:
- WIDTH, 8, number of pad channels (1..64).
- WEAK_KEEPER, "NONE", pad keeper passed to every bit: NONE/PULLUP/PULLDOWN.
- SYNC_STAGES, 2, receive synchroniser depth (2..4).
- FILTER_LEN, 4, consecutive stable cycles before a filtered bit updates (0 = filter bypassed).
- TURNAROUND, 2, dead cycles with pad released on each direction change (1..15).

Ports:
- CLK  input  1  single clock for all state.
- RST  input  1  asynchronous active-high reset.
- DIR_REQ  input  1  requested direction: 1 = drive pads, 0 = receive.
- TX_DATA  input  WIDTH  data to drive; sampled every cycle while in TX.
- RX_DATA  output  WIDTH  synchronised, filtered pad value.
- RX_CHG  output  1  one-cycle pulse when any RX_DATA bit changes.
- DIR_ACK  output  1  current settled direction: 1 = TX, 0 = RX.
- BUSY  output  1  high during turnaround.
- IO  inout  WIDTH  pad bus.

Behaviour:
Reset:
- State RX. Pads released (high-Z).
- RX_DATA=0, RX_CHG=0, DIR_ACK=0, BUSY=0.
- Synchroniser flops, filter counters and the output register are all 0.

State machine (registered):
- RX: if DIR_REQ=1, go to TA_TX and load the turnaround counter with TURNAROUND-1.
- TA_TX: pads released, BUSY=1. Count down; at 0 go to TX.
- TX: pads driven. If DIR_REQ=0, go to TA_RX and load the counter.
- TA_RX: pads released, BUSY=1. Count down; at 0 go to RX.
- DIR_REQ changing during a turnaround is ignored. The turnaround completes, then the new state re-evaluates DIR_REQ on the next cycle.
- DIR_ACK=1 only in TX; it goes to 1 on the first cycle the pads are driven.

Drive path:
- Output register loads TX_DATA every cycle in TX. Pads show TX_DATA one cycle later.
- Output enable is registered, so there is no combinational path from DIR_REQ to the pad enable.
- On leaving TX, the enable drops in the same cycle the state leaves TX.
- Latency from DIR_REQ rising to pads driven: TURNAROUND+1 cycles.

Receive path:
- Each bit is synchronised through SYNC_STAGES flops. The path is active in every state.
- Per-bit filter counter, width clog2(FILTER_LEN+1):
  - Resets to 0 when the synchronised bit equals RX_DATA, or differs from the previous synchronised sample.
  - Otherwise it increments. At FILTER_LEN, RX_DATA takes the new value and the counter clears.
  - The counter saturates and never wraps.
- FILTER_LEN=0: RX_DATA follows the synchroniser output with one register stage.
- RX_CHG is registered and is 1 in the cycle RX_DATA updates. In TX it reflects the bank's own driven values.

RST mid-transfer:
- Pads are released immediately, asynchronously.
- All state is as in reset. The next transition requires DIR_REQ=1 after RST deasserts.

Test Plan:
- Reset with IO pulled to all-ones -> IO high-Z, RX_DATA=0x00. After SYNC_STAGES+FILTER_LEN+1 = 7 cycles, RX_DATA=0xFF with a single RX_CHG pulse.
- DIR_REQ 0->1 at cycle 10, TURNAROUND=2, TX_DATA=0xA5 -> BUSY=1 on cycles 11-12, DIR_ACK=1 and IO=0xA5 from cycle 13. IO is never driven while BUSY=1.
- In TX, toggle DIR_REQ 1->0->1 within one cycle during TA_RX -> full TA_RX completes, one RX cycle follows, then a full TA_TX. Check the whole BUSY/DIR_ACK sequence.
- Glitch: bit 3 pulses high for 3 cycles with FILTER_LEN=4 -> RX_DATA unchanged, no RX_CHG. A 4-cycle-plus pulse -> RX_DATA[3]=1 with exactly one RX_CHG.
- Assert RST during TX with IO=0x3C -> IO high-Z in the same cycle, all outputs 0. After RST release with DIR_REQ held 1, TX resumes after TURNAROUND+1 cycles.
- FILTER_LEN=0, WIDTH=1 build -> RX_DATA lags the pad by SYNC_STAGES+1 cycles, with one RX_CHG per edge.
